// File: rtl/byte_serializer.sv
// Parallel-in, LSB-first serial-out transmitter paced by an external bit strobe.
// A one-word holding register lets the next word follow the current one with no idle bit slots.
module byte_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         load,
  output logic         ready,
  input  logic         en,
  output logic         so,
  output logic         so_valid,
  output logic         last,
  output logic         busy
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  // Handshake: a word is taken on a rising edge where load && ready; ready is
  // high exactly when the holding register is empty, and load is ignored otherwise.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic active;
  logic accept;

  assign active = (state_q == SHIFT);
  assign accept = load && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sh_d        = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (hold_full_q) begin
              // Chain straight into the buffered word so no bit slot is lost.
              sh_d        = hold_q;
              hold_full_d = 1'b0;
            end else begin
              sh_d    = sh_q >> 1;
              state_d = IDLE;
            end
          end else begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Never overlaps a transfer out of the holding register since ready=0 then.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ready    = !hold_full_q;
  assign busy     = active || hold_full_q;
  assign so       = active ? sh_q[0] : 1'b0;
  assign so_valid = en && active;
  assign last     = so_valid && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: a word-level model (holding flag, current word,
// bits remaining) predicts every output each cycle; received words are scored.
module tb_byte_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         load;
  logic         en;
  logic         ready;
  logic         so;
  logic         so_valid;
  logic         last;
  logic         busy;

  byte_serializer #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .load     (load),
    .ready    (ready),
    .en       (en),
    .so       (so),
    .so_valid (so_valid),
    .last     (last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic         m_hold_full;
  logic [W-1:0] m_hold;
  logic [W-1:0] m_cur;
  int           m_left;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_word;
  logic [W-1:0] last_word;
  int           n_words;
  int           n_sent;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold_full = 1'b0;
    m_hold      = '0;
    m_cur       = '0;
    m_left      = 0;
    rx_word     = '0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, check outputs, advance the model at posedge.
  task automatic step(input logic l, input logic [W-1:0] d, input logic e);
    logic ex_valid, ex_so, ex_last, acc;
    load = l;
    din  = d;
    en   = e;
    #1;
    ex_valid = e && (m_left > 0);
    ex_so    = (m_left > 0) ? m_cur[W - m_left] : 1'b0;
    ex_last  = ex_valid && (m_left == 1);
    check("ready", ready, !m_hold_full);
    check("busy", busy, (m_left > 0) || m_hold_full);
    check("so_valid", so_valid, ex_valid);
    check("last", last, ex_last);
    check("so", so, ex_so);
    if (ex_valid) begin
      rx_word = {so, rx_word[W-1:1]};
      if (ex_last) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_word", rx_word, exp_q.pop_front());
        last_word = rx_word;
        n_words++;
      end
    end
    acc = l && !m_hold_full;
    @(posedge clk);
    if (m_left == 0) begin
      if (m_hold_full) begin
        m_cur = m_hold; m_left = W; m_hold_full = 1'b0;
      end
    end else if (e) begin
      m_left--;
      if (m_left == 0 && m_hold_full) begin
        m_cur = m_hold; m_left = W; m_hold_full = 1'b0;
      end
    end
    if (acc) begin
      m_hold = d; m_hold_full = 1'b1;
      exp_q.push_back(d);
      n_sent++;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic e);
    int t = 0;
    while (m_hold_full && t < 64) begin
      step(1'b0, '0, e);
      t++;
    end
    if (t == 64) check("send_timeout", 1, 0);
    step(1'b1, d, e);
  endtask

  task automatic drain();
    int t = 0;
    while ((m_left > 0 || m_hold_full) && t < 200) begin
      step(1'b0, '0, 1'b1);
      t++;
    end
    if (t == 200) check("drain_timeout", 1, 0);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic reset_now(input logic e);
    rst = 1'b1;
    en  = e;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_so", so, 0);
    check("rst_so_valid", so_valid, 0);
    check("rst_last", last, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int w0, lc, sent, cyc, valid_bits;
    rst = 1'b0; load = 1'b0; en = 1'b0; din = '0;
    n_words = 0; n_sent = 0; last_word = '0;
    model_reset();

    // Asynchronous reset away from any clock edge
    #2;
    reset_now(1'b1);

    // Single word 0xA5
    w0 = n_words;
    send(8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    check("a5_words", n_words - w0, 1);
    check("a5_word", last_word, 8'hA5);

    // Back-to-back 0x3C, 0xC3, then a load that must be dropped
    w0 = n_words;
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    check("b2b_words", n_words - w0, 2);
    check("b2b_second", last_word, 8'hC3);

    // Strobe alternating 1,0,1,0...
    w0 = n_words;
    send(8'h96, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, '0, (i % 2) == 0);
    check("gap_words", n_words - w0, 1);
    check("gap_word", last_word, 8'h96);

    // Reset after 4 bits of 0xFF, then 0x01
    send(8'hFF, 1'b1);
    valid_bits = 0;
    cyc = 0;
    while (valid_bits < 4 && cyc < 20) begin
      if (m_left > 0) valid_bits++;
      step(1'b0, '0, 1'b1);
      cyc++;
    end
    reset_now(1'b1);
    w0 = n_words;
    send(8'h01, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    check("post_rst_words", n_words - w0, 1);
    check("post_rst_word", last_word, 8'h01);

    // Random words with random strobe gaps and load attempts
    sent = n_sent;
    cyc  = 0;
    while ((n_sent - sent) < 256 && cyc < 20000) begin
      lc = $urandom_range(0, 3);
      step(lc != 0, W'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
      cyc++;
    end
    if (cyc == 20000) check("rand_timeout", 1, 0);
    drain();
    check("sb_empty", exp_q.size(), 0);
    check("words_total", n_words, n_sent - 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Parallel-in, serial-out transmitter that converts W-bit words into an LSB-first bit stream paced by an external bit strobe. It is the transmit-side counterpart of the team's `qb` deserializer. `so` drives `si`, `so_valid` drives `en`, and `last` coincides with `qb`'s `co` on the final bit of each word. A one-word holding register lets the next word stream with no idle bit slots between words.

## Interface
- W, 8, word width; bit counter width is $clog2(W)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  W  parallel word to transmit
- load  input  1  word valid; accepted on a rising edge when `load && ready`
- ready  output  1  holding register empty; `ready = !hold_full`
- en  input  1  bit strobe; one bit is emitted per cycle with `en=1` while active
- so  output  1  serial data; `sh_q[0]` when active, else 0
- so_valid  output  1  `en && active`; marks the cycle in which `so` is a valid bit
- last  output  1  `so_valid && cnt == W-1`; final bit of a word
- busy  output  1  `active || hold_full`

## Operation
- State:
  - hold_q[W-1:0] and hold_full (holding buffer)
  - sh_q[W-1:0] (shift register)
  - cnt (bit index, 0..W-1)
  - active (IDLE when 0, SHIFT when 1)
- Accept: on an edge with `load && ready`, hold_q <= din and hold_full <= 1.
  - load is ignored when ready=0; the word is not captured and there is no error flag.
  - load and a hold transfer can never coincide, because ready=0 whenever hold_full=1.
- IDLE -> SHIFT: on an edge with active=0 and hold_full=1:
  - sh_q <= hold_q, cnt <= 0, active <= 1, hold_full <= 0.
  - en is ignored on this edge.
- SHIFT bit step: on an edge with active=1 and en=1:
  - sh_q <= sh_q >> 1 (zero fill), cnt <= cnt + 1.
- End of word: on a bit-step edge with cnt == W-1:
  - If hold_full=1: reload sh_q <= hold_q, cnt <= 0, hold_full <= 0, active stays 1 (no gap).
  - Else: active <= 0, cnt <= 0.
- active=1 with en=0: all state holds. The stream may stall indefinitely mid-word.
- en while IDLE: no effect. so, so_valid and last stay 0.
- Bit order: din[0] is sent first and din[W-1] last, so `qb` reconstructs the same word.
- Reset (asynchronous, any time, including mid-word):
  - hold_q, sh_q, cnt, hold_full, active all clear to 0.
  - Any partial word is discarded.
  - Outputs after reset: so=0, so_valid=0, last=0, busy=0, ready=1.

## Timing
- so, so_valid and last are combinational from registered state and en. ready and busy are combinational from registers only.
- Latency, idle block: load accepted at edge k -> shifter loaded at edge k+1 -> first bit valid in the first en=1 cycle after edge k+1. With en tied to 1, bit 0 appears in cycle k+1..k+2.
- Throughput: with en=1 continuously and the next word loaded before the current word's last bit, the stream is W valid bits per W cycles with no gaps.
- ready rises in the cycle after the hold transfer. The producer has at most W en-cycles to supply the next word to avoid a gap.
- last is high for exactly one so_valid cycle per word.

## Test plan
- Reset: assert rst mid-clock with no edge -> immediately ready=1, busy=0, so=0, so_valid=0, last=0.
- Single word, W=8: din=0xA5, load for one cycle, en=1.
  - so over 8 consecutive so_valid cycles = 1,0,1,0,0,1,0,1.
  - last is high only on the 8th bit; busy=0 the cycle after.
- Back-to-back: load 0x3C, then load 0xC3 as soon as ready returns, en=1.
  - 16 contiguous so_valid cycles; last on bits 8 and 16.
  - ready=0 from the second accept until its transfer.
  - A third load attempted while ready=0 is dropped.
- Gapped strobe: 0x96 with en toggling 1,0,1,0...
  - Bits appear only in en=1 cycles, sequence 0,1,1,0,1,0,0,1.
  - sh_q and cnt are unchanged on en=0 cycles.
- Reset mid-word: send 0xFF, assert rst after 4 bits.
  - so=0 and busy=0 immediately.
  - A following 0x01 transmits as 1,0,0,0,0,0,0,0 with last on bit 8.
- Loopback: so->si, so_valid->en of `qb`; 256 random words with random en gaps.
  - `qb.out` equals each sent word in the cycle after `co`.
  - `co` and last are high in the same cycles.
